chunked_comparator: RTL

- Multi-cycle magnitude comparator for two WIDTH-bit operands.
- Compares CHUNK bits per cycle, most-significant chunk first, and stops at the first differing chunk.
- Supports unsigned and two's-complement signed comparison, selected per operation.
- Replaces single-cycle flat comparators on the datapath's branch/compare path; its start/busy/done handshake lets the control unit stall on wide operands without lengthening the critical path.

---
 rtl/chunked_comparator.sv | 100 ++++++++++
 1 files changed

// File: rtl/chunked_comparator.sv
// chunked_comparator: multi-cycle magnitude comparator.
// Operands are compared CHUNK bits per cycle, most-significant chunk first,
// and the operation ends at the first chunk that differs. A signed compare
// is turned into an unsigned one by flipping both sign bits when latched.
module chunked_comparator #(
  parameter int WIDTH = 18,
  parameter int CHUNK = 6
) (
  input  logic                                clk,
  input  logic                                rst_n,
  input  logic                                start,
  input  logic                                is_signed,
  input  logic [WIDTH-1:0]                    a,
  input  logic [WIDTH-1:0]                    b,
  output logic                                busy,
  output logic                                done,
  output logic                                above,
  output logic                                equal,
  output logic                                below,
  output logic [$clog2(WIDTH/CHUNK+1)-1:0]    cycles
);

  localparam int NCHUNK = WIDTH / CHUNK;
  localparam int CW     = $clog2(NCHUNK + 1);
  localparam int IW     = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;

  typedef enum logic {IDLE, CMP} state_t;

  state_t           state;
  logic [WIDTH-1:0] opa;
  logic [WIDTH-1:0] opb;
  logic [IW-1:0]    idx;
  logic [CHUNK-1:0] chunk_a;
  logic [CHUNK-1:0] chunk_b;
  logic [WIDTH-1:0] sign_mask;

  // Flipping the MSB of both operands maps two's-complement order onto
  // unsigned order, so one unsigned chunk compare serves both modes.
  assign sign_mask = {is_signed, {(WIDTH-1){1'b0}}};

  // Busy comes straight from the registered state, never from start.
  assign busy = (state == CMP);

  // Select the chunk currently under comparison.
  always_comb begin
    chunk_a = opa[int'(idx)*CHUNK +: CHUNK];
    chunk_b = opb[int'(idx)*CHUNK +: CHUNK];
  end

  // Control FSM with registered result flags, done pulse and cycle count.
  // NOTE: all state here is updated with non-blocking assignments so every
  // register samples the pre-edge values, regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      opa    <= '0;
      opb    <= '0;
      idx    <= '0;
      done   <= 1'b0;
      above  <= 1'b0;
      equal  <= 1'b0;
      below  <= 1'b0;
      cycles <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            opa    <= a ^ sign_mask;
            opb    <= b ^ sign_mask;
            idx    <= IW'(NCHUNK - 1);
            above  <= 1'b0;
            equal  <= 1'b0;
            below  <= 1'b0;
            cycles <= '0;
            state  <= CMP;
          end
        end
        CMP: begin
          if (chunk_a != chunk_b) begin
            above  <= (chunk_a > chunk_b);
            below  <= (chunk_a < chunk_b);
            cycles <= CW'(NCHUNK - int'(idx));
            done   <= 1'b1;
            state  <= IDLE;
          end else if (idx == '0) begin
            equal  <= 1'b1;
            cycles <= CW'(NCHUNK);
            done   <= 1'b1;
            state  <= IDLE;
          end else begin
            idx <= idx - 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
